// File: rtl/nbody_pipe_pkg.sv
// Shared types for the n-body delay/compute pipeline and its result buffer.
package nbody_pipe_pkg;

  // Width of one pipeline result word.
  localparam int DATA_W = 64;

  typedef logic [DATA_W-1:0] data_t;

endpackage : nbody_pipe_pkg

// File: rtl/result_fifo_mem.sv
// Result storage for the pipeline result buffer: DEPTH entries, one write
// port, one combinational (show-ahead) read port. Storage is not reset; the
// owner decides which entries are meaningful.
module result_fifo_mem
  import nbody_pipe_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  data_t entries [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    data_t entry_reg;

    // Capture the incoming result when this entry is the write target.
    always_ff @(posedge clk) begin
      if (wr_en && (wr_addr == AW'(gi))) begin
        entry_reg <= wr_data;
      end
    end

    assign entries[gi] = entry_reg;
  end

  assign rd_data = entries[rd_addr];

endmodule : result_fifo_mem

// File: rtl/pipeline_result_buffer.sv
// Receive-side endpoint of a fixed-latency pipeline. Results leaving the
// pipeline tail are queued in a small FIFO and offered downstream over
// valid/ready. Upstream issues are gated by credits so every item already in
// the pipeline is guaranteed a FIFO slot when it emerges, since the pipeline
// itself cannot be stalled.
module pipeline_result_buffer
  import nbody_pipe_pkg::*;
#(
  parameter int DEPTH          = 8,
  parameter int LATENCY        = 4,
  parameter bit CHECK_PROTOCOL = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   issue_valid,
  output logic                   issue_ready,
  input  logic                   pipe_valid,
  input  logic [DATA_W-1:0]      pipe_data,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_data,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic [$clog2(DEPTH):0] inflight,
  output logic                   protocol_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic [CW-1:0] inflight_reg, inflight_next;
  logic          err_reg, err_next;
  logic          saw_full_reg, saw_full_next;

  logic          fire;
  logic          pop;
  logic          wr_accept;
  logic [CW:0]   credit_sum;
  data_t         rd_data;

  // Credits come only from registered counters so no input can ripple
  // combinationally into issue_ready.
  assign credit_sum  = {1'b0, count_reg} + {1'b0, inflight_reg};
  assign issue_ready = credit_sum < {1'b0, FULL_C};

  assign out_valid = (count_reg != '0);
  // Zero the head word when empty so the output is deterministic after reset.
  assign out_data  = out_valid ? rd_data : '0;

  assign count        = count_reg;
  assign inflight     = inflight_reg;
  assign protocol_err = err_reg;

  assign fire      = issue_valid && issue_ready;
  assign pop       = out_valid && out_ready;
  // A full FIFO can still take a result if the head leaves in the same cycle.
  assign wr_accept = pipe_valid && ((count_reg != FULL_C) || pop);

  result_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_accept),
    .wr_addr (wr_ptr_reg),
    .wr_data (pipe_data),
    .rd_addr (rd_ptr_reg),
    .rd_data (rd_data)
  );

  // Next-state for pointers, occupancy, credits in flight and the error flag.
  always_comb begin
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    count_next    = count_reg;
    inflight_next = inflight_reg;
    err_next      = err_reg;
    saw_full_next = saw_full_reg;

    if (wr_accept) begin
      wr_ptr_next = wr_ptr_reg + 1'b1;
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + 1'b1;
    end

    case ({wr_accept, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase

    // A tail result with nothing in flight is an upstream fault; the counter
    // holds at zero rather than wrapping.
    case ({fire, pipe_valid})
      2'b10:   inflight_next = inflight_reg + 1'b1;
      2'b01:   inflight_next = (inflight_reg != '0) ? inflight_reg - 1'b1 : '0;
      default: inflight_next = inflight_reg;
    endcase

    if (pipe_valid && ((inflight_reg == '0) || ((count_reg == FULL_C) && !pop))) begin
      err_next = 1'b1;
    end

    if (count_reg == FULL_C) begin
      saw_full_next = 1'b1;
    end else if (count_reg == '0) begin
      saw_full_next = 1'b0;
    end
  end

  // State register; reset forgets everything, including results in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      inflight_reg <= '0;
      err_reg      <= 1'b0;
      saw_full_reg <= 1'b0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      inflight_reg <= inflight_next;
      err_reg      <= err_next;
      saw_full_reg <= saw_full_next;
    end
  end

  // Credits never over-commit the FIFO while the upstream behaves.
  a_credit_bound: assert property (@(posedge clk) disable iff (rst || err_reg)
    credit_sum <= {1'b0, FULL_C});

  // A stalled head must not change under the consumer.
  a_out_hold: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_data)));

  // Structural sanity of the configuration.
  a_params: assert property (@(posedge clk) (DEPTH >= 2) && (LATENCY >= 1));

  if (CHECK_PROTOCOL) begin : g_protocol_check
    a_no_protocol_err: assert property (@(posedge clk) disable iff (rst) !err_reg);
  end

  // Reached full at some point and later drained back to empty.
  c_full_then_drain: cover property (@(posedge clk) disable iff (rst)
    saw_full_reg && (count_reg == '0));

endmodule : pipeline_result_buffer

// File: tb/tb_pipeline_result_buffer.sv
// Directed, table-driven bench for pipeline_result_buffer with a small
// fixed-latency pipeline model for the streaming sequences.
module tb_pipeline_result_buffer;
  import nbody_pipe_pkg::*;

  localparam int DEPTH   = 8;
  localparam int LATENCY = 4;
  localparam int CW      = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          issue_valid = 1'b0;
  logic          issue_ready;
  logic          pipe_valid;
  logic [63:0]   pipe_data;
  logic          out_valid;
  logic [63:0]   out_data;
  logic          out_ready = 1'b0;
  logic [CW-1:0] count;
  logic [CW-1:0] inflight;
  logic          protocol_err;

  logic          use_pipe = 1'b0;
  logic          man_pv = 1'b0;
  logic [63:0]   man_pd = '0;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipeline_result_buffer #(
    .DEPTH          (DEPTH),
    .LATENCY        (LATENCY),
    .CHECK_PROTOCOL (1'b0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .pipe_valid   (pipe_valid),
    .pipe_data    (pipe_data),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .count        (count),
    .inflight     (inflight),
    .protocol_err (protocol_err)
  );

  // Fixed-latency pipeline model: an issue fire enters stage 0 and leaves the
  // tail LATENCY edges later carrying a sequence number.
  logic        sr_v [LATENCY];
  logic [63:0] sr_d [LATENCY];
  int fires = 0;
  int fire_base = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        sr_v[i] <= 1'b0;
        sr_d[i] <= '0;
      end
    end else begin
      for (int i = LATENCY - 1; i > 0; i--) begin
        sr_v[i] <= sr_v[i-1];
        sr_d[i] <= sr_d[i-1];
      end
      sr_v[0] <= use_pipe && issue_valid && issue_ready;
      sr_d[0] <= 64'(fires - fire_base + 1);
      if (use_pipe && issue_valid && issue_ready) fires <= fires + 1;
    end
  end

  assign pipe_valid = use_pipe ? sr_v[LATENCY-1] : man_pv;
  assign pipe_data  = use_pipe ? sr_d[LATENCY-1] : man_pd;

  // Record every result the consumer takes.
  logic [63:0] rx_q [$];
  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) rx_q.push_back(out_data);
  end

  typedef struct {
    logic        iv;
    logic        pv;
    logic [63:0] pd;
    logic        ordy;
    logic        e_ir;
    logic        e_ov;
    logic [63:0] e_od;
    int          e_cnt;
    int          e_inf;
    logic        e_err;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t mk(logic iv, logic pv, logic [63:0] pd, logic ordy,
                              logic e_ir, logic e_ov, logic [63:0] e_od,
                              int e_cnt, int e_inf, logic e_err);
    vec_t v;
    v.iv = iv; v.pv = pv; v.pd = pd; v.ordy = ordy;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od;
    v.e_cnt = e_cnt; v.e_inf = e_inf; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply each row for one clock, then compare the registered outputs.
  task automatic run_table(input string tag);
    foreach (tbl[i]) begin
      issue_valid = tbl[i].iv;
      man_pv      = tbl[i].pv;
      man_pd      = tbl[i].pd;
      out_ready   = tbl[i].ordy;
      tick();
      chk($sformatf("%s[%0d].issue_ready", tag, i), 64'(issue_ready), 64'(tbl[i].e_ir));
      chk($sformatf("%s[%0d].out_valid", tag, i), 64'(out_valid), 64'(tbl[i].e_ov));
      chk($sformatf("%s[%0d].count", tag, i), 64'(count), 64'(tbl[i].e_cnt));
      chk($sformatf("%s[%0d].inflight", tag, i), 64'(inflight), 64'(tbl[i].e_inf));
      chk($sformatf("%s[%0d].protocol_err", tag, i), 64'(protocol_err), 64'(tbl[i].e_err));
      if (tbl[i].e_ov) chk($sformatf("%s[%0d].out_data", tag, i), out_data, tbl[i].e_od);
      $display("%s row %0d: count=%0d inflight=%0d out_valid=%0b out_data=%0h",
               tag, i, count, inflight, out_valid, out_data);
    end
    issue_valid = 1'b0;
    man_pv      = 1'b0;
    out_ready   = 1'b0;
    tbl.delete();
  endtask

  // Round trip of one item through an idle buffer.
  task automatic load_t1();
    tbl.push_back(mk(0, 0, 64'h0, 0, 1, 0, 64'h0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 64'h0, 0, 1, 0, 64'h0, 0, 1, 0));
    for (int k = 0; k < LATENCY - 1; k++)
      tbl.push_back(mk(0, 0, 64'h0, 0, 1, 0, 64'h0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 64'hDEAD_BEEF_0000_0001, 1, 1, 1, 64'hDEAD_BEEF_0000_0001, 1, 0, 0));
    tbl.push_back(mk(0, 0, 64'h0, 1, 1, 0, 64'h0, 0, 0, 0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rx_base;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset.issue_ready", 64'(issue_ready), 64'd1);
    chk("reset.out_valid", 64'(out_valid), 64'd0);
    chk("reset.out_data", out_data, 64'd0);
    chk("reset.count", 64'(count), 64'd0);
    chk("reset.inflight", 64'(inflight), 64'd0);
    chk("reset.protocol_err", 64'(protocol_err), 64'd0);
    rst = 1'b0;

    load_t1();
    run_table("roundtrip");

    // Credit exhaustion with the consumer stalled
    use_pipe    = 1'b1;
    fire_base   = fires;
    out_ready   = 1'b0;
    issue_valid = 1'b1;
    repeat (20) tick();
    issue_valid = 1'b0;
    chk("exhaust.fires", 64'(fires - fire_base), 64'd8);
    chk("exhaust.issue_ready", 64'(issue_ready), 64'd0);
    chk("exhaust.count", 64'(count), 64'd8);
    chk("exhaust.inflight", 64'(inflight), 64'd0);
    chk("exhaust.head", out_data, 64'd1);
    $display("exhaust: fires=%0d count=%0d inflight=%0d", fires - fire_base, count, inflight);
    use_pipe = 1'b0;

    // Pop re-raises credit, then simultaneous fire/pop/tail events and drain
    tbl.push_back(mk(1, 0, 64'h0,   1, 1, 1, 64'h2, 7, 0, 0));
    tbl.push_back(mk(1, 0, 64'h0,   0, 0, 1, 64'h2, 7, 1, 0));
    tbl.push_back(mk(0, 1, 64'h100, 1, 1, 1, 64'h3, 7, 0, 0));
    tbl.push_back(mk(1, 0, 64'h0,   1, 1, 1, 64'h4, 6, 1, 0));
    tbl.push_back(mk(1, 1, 64'h101, 0, 0, 1, 64'h4, 7, 1, 0));
    tbl.push_back(mk(0, 1, 64'h102, 0, 0, 1, 64'h4, 8, 0, 0));
    for (int k = 0; k < 7; k++) begin
      logic [63:0] hv;
      hv = (k < 4) ? 64'(5 + k) : 64'(64'h100 + (k - 4));
      tbl.push_back(mk(0, 0, 64'h0, 1, 1, 1, hv, 7 - k, 0, 0));
    end
    tbl.push_back(mk(0, 0, 64'h0, 1, 1, 0, 64'h0, 0, 0, 0));
    run_table("simul");

    // Stream 1..20 through the pipeline with a randomly stalling consumer
    use_pipe  = 1'b1;
    fire_base = fires;
    rx_base   = rx_q.size();
    for (int c = 0; c < 600 && (rx_q.size() - rx_base) < 20; c++) begin
      issue_valid = (fires - fire_base) < 20;
      out_ready   = ($urandom_range(0, 1) == 1);
      tick();
    end
    issue_valid = 1'b0;
    out_ready   = 1'b0;
    chk("wrap.received", 64'(rx_q.size() - rx_base), 64'd20);
    for (int k = 0; k < 20; k++) begin
      if (rx_base + k < rx_q.size()) begin
        chk($sformatf("wrap.item%0d", k), rx_q[rx_base + k], 64'(k + 1));
        $display("wrap: item %0d data=%0h", k, rx_q[rx_base + k]);
      end
    end
    chk("wrap.protocol_err", 64'(protocol_err), 64'd0);
    chk("wrap.count", 64'(count), 64'd0);
    chk("wrap.inflight", 64'(inflight), 64'd0);
    use_pipe = 1'b0;

    // Protocol errors: tail with nothing in flight, overflow drop, full+pop
    tbl.push_back(mk(0, 1, 64'hAA, 0, 1, 1, 64'hAA, 1, 0, 1));
    tbl.push_back(mk(0, 0, 64'h0,  0, 1, 1, 64'hAA, 1, 0, 1));
    for (int k = 0; k < 7; k++)
      tbl.push_back(mk(0, 1, 64'(64'hB1 + k), 0, (k < 6), 1, 64'hAA, 2 + k, 0, 1));
    tbl.push_back(mk(0, 1, 64'hCC, 0, 0, 1, 64'hAA, 8, 0, 1));
    tbl.push_back(mk(0, 1, 64'hDD, 1, 0, 1, 64'hB1, 8, 0, 1));
    for (int k = 0; k < 7; k++) begin
      logic [63:0] hv;
      hv = (k < 6) ? 64'(64'hB2 + k) : 64'hDD;
      tbl.push_back(mk(0, 0, 64'h0, 1, 1, 1, hv, 7 - k, 0, 1));
    end
    tbl.push_back(mk(0, 0, 64'h0, 1, 1, 0, 64'h0, 0, 0, 1));
    run_table("proterr");

    rst = 1'b1;
    #2;
    chk("proterr.cleared", 64'(protocol_err), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset in the middle of traffic
    issue_valid = 1'b1;
    repeat (5) tick();
    issue_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      man_pv = 1'b1;
      man_pd = 64'(64'h11 + k);
      tick();
    end
    man_pv = 1'b0;
    chk("midrst.pre_count", 64'(count), 64'd3);
    chk("midrst.pre_inflight", 64'(inflight), 64'd2);
    #3;
    rst = 1'b1;
    #1;
    chk("midrst.out_valid", 64'(out_valid), 64'd0);
    chk("midrst.count", 64'(count), 64'd0);
    chk("midrst.inflight", 64'(inflight), 64'd0);
    chk("midrst.issue_ready", 64'(issue_ready), 64'd1);
    $display("midrst: count=%0d inflight=%0d out_valid=%0b", count, inflight, out_valid);
    @(posedge clk);
    #1;
    rst = 1'b0;
    load_t1();
    run_table("resume");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_pipeline_result_buffer
